seven_seg_scan: RTL and testbench

- Downstream consumer of the cascaded decade-counter chain.
- Takes four 4-bit BCD digit values (ones through thousands) and time-multiplexes them onto a common-anode 4-digit seven-segment display.
- Inserts a one-cycle anode dead-time between digits to prevent ghosting.
- Snapshots all digits once per scan frame so a carry rippling through the counters never shows as a torn value.

---
 rtl/seven_seg_scan.sv | 121 ++++++++++++
 tb/tb_seven_seg_scan.sv | 119 +++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner with one-cycle anode dead-time
// and per-frame digit snapshot. Define SEG_HEX_EN to show 10-15 as hex A-F.
module seven_seg_scan #(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic {BLANK, DRIVE} state_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLK_DIV - 1);
  localparam logic [6:0]       SEG_OFF = 7'b1111111;

  state_t           state;
  logic [1:0]       idx;
  logic [CNT_W-1:0] prescaler;
  logic [15:0]      snap;
  logic [3:0]       dp_snap;

  logic [15:0] src;
  logic [3:0]  dp_src;
  logic [3:0]  cur;
  logic [3:0]  zero;
  logic        lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
`ifdef SEG_HEX_EN
      4'd10:   decode = 7'b0001000;
      4'd11:   decode = 7'b0000011;
      4'd12:   decode = 7'b1000110;
      4'd13:   decode = 7'b0100001;
      4'd14:   decode = 7'b0000110;
      default: decode = 7'b0001110;
`else
      default: decode = 7'b0111111;
`endif
    endcase
  endfunction

  // Digit 0 starts a frame, so it reads the live inputs that are being
  // snapshotted on the same edge; later digits read the frozen snapshot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    src      = (idx == 2'd0) ? digits : snap;
    dp_src   = (idx == 2'd0) ? dp_in  : dp_snap;
    cur      = src[{idx, 2'b00} +: 4];
    lz_blank = 1'b0;
    for (int i = 0; i < 4; i++) zero[i] = (snap[4*i +: 4] == 4'd0);
    if (lz_en) begin
      case (idx)
        2'd1:    lz_blank = zero[3] & zero[2] & zero[1];
        2'd2:    lz_blank = zero[3] & zero[2];
        2'd3:    lz_blank = zero[3];
        default: lz_blank = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BLANK;
      idx       <= 2'd0;
      prescaler <= '0;
      // NOTE: the snapshot is a handful of flops, not a memory, so it is reset too.
      snap      <= 16'h0000;
      dp_snap   <= 4'h0;
      an        <= 4'b1111;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      case (state)
        BLANK: begin
          state     <= DRIVE;
          prescaler <= '0;
          an        <= ~(4'b0001 << idx);
          seg       <= lz_blank ? SEG_OFF : decode(cur);
          dp        <= ~dp_src[idx];
          if (idx == 2'd0) begin
            snap    <= digits;
            dp_snap <= dp_in;
          end
        end
        DRIVE: begin
          if (prescaler == LAST) begin
            state     <= BLANK;
            prescaler <= '0;
            idx       <= idx + 2'd1;
            an        <= 4'b1111;
            seg       <= SEG_OFF;
            dp        <= 1'b1;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan at CLK_DIV=4: walks whole frames cycle by
// cycle against hand-computed {an, seg, dp} values.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] OFF  = 7'b1111111;
  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S9   = 7'b0010000;
`ifdef SEG_HEX_EN
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SF   = 7'b0001110;
`else
  localparam logic [6:0] SA   = 7'b0111111;
  localparam logic [6:0] SF   = 7'b0111111;
`endif

  seven_seg_scan #(.CLK_DIV(4), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .digits (digits),
    .dp_in  (dp_in),
    .lz_en  (lz_en),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {an,seg,dp}=%b_%b_%b expected %b_%b_%b",
               tag, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Called with the DUT in BLANK at idx 0, just after a negedge. Checks one
  // full frame: 4 drive cycles then 1 blank cycle per digit. Optionally
  // changes digits on the first drive cycle of slot chg_slot.
  task automatic run_frame(input string tag,
                           input logic [6:0] e0, input logic [6:0] e1,
                           input logic [6:0] e2, input logic [6:0] e3,
                           input logic [3:0] exp_dp,
                           input int chg_slot, input logic [15:0] chg_digits);
    logic [6:0] es [4];
    logic [3:0] exp_an;
    es[0] = e0; es[1] = e1; es[2] = e2; es[3] = e3;
    for (int i = 0; i < 4; i++) begin
      exp_an = ~(4'b0001 << i);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check($sformatf("%s d%0d c%0d", tag, i, c), {an, seg, dp}, {exp_an, es[i], exp_dp[i]});
        if (i == chg_slot && c == 0) digits = chg_digits;
      end
      @(negedge clk);
      check($sformatf("%s blank%0d", tag, i), {an, seg, dp}, {4'b1111, OFF, 1'b1});
    end
  endtask

  initial begin
    #12;
    check("reset", {an, seg, dp}, {4'b1111, OFF, 1'b1});

    digits = 16'h1234;
    @(negedge clk);
    check("reset held", {an, seg, dp}, {4'b1111, OFF, 1'b1});
    rst = 1'b1;
    run_frame("f1234", S4, S3, S2, S1, 4'b1111, -1, 16'h0);

    digits = 16'h0050; lz_en = 1'b1;
    run_frame("f0050", S0, S5, OFF, OFF, 4'b1111, -1, 16'h0);

    digits = 16'h0000;
    run_frame("f0000", S0, OFF, OFF, OFF, 4'b1111, -1, 16'h0);

    digits = 16'h0999; lz_en = 1'b0;
    run_frame("f0999", S9, S9, S9, S0, 4'b1111, 2, 16'h1000);
    run_frame("f1000", S0, S0, S0, S1, 4'b1111, -1, 16'h0);

    digits = 16'h0123; dp_in = 4'b0100; lz_en = 1'b1;
    run_frame("fdp", S3, S2, S1, OFF, 4'b1011, -1, 16'h0);

    digits = 16'h00AF; dp_in = 4'b0000; lz_en = 1'b0;
    run_frame("f00AF", SF, SA, S0, S0, 4'b1111, -1, 16'h0);

    // Mid-DRIVE reset of digit 2: negedges 1-4 d0, 5 blank, 6-9 d1, 10 blank, 11-14 d2.
    repeat (12) @(negedge clk);
    check("pre-reset d2", {an, seg, dp}, {4'b1011, S0, 1'b1});
    #2 rst = 1'b0;
    #1 check("async reset", {an, seg, dp}, {4'b1111, OFF, 1'b1});
    @(negedge clk);
    check("reset low", {an, seg, dp}, {4'b1111, OFF, 1'b1});
    rst = 1'b1;
    @(negedge clk);
    check("restart d0", {an, seg, dp}, {4'b1110, SF, 1'b1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
